// File: rtl/qpu_dmem_icb_arbt_pkg.sv
// qpu_dmem_icb_arbt_pkg: shared widths and the requester-id type for the data-memory ICB arbiter.
package qpu_dmem_icb_arbt_pkg;
    localparam int QPU_ADDR_SIZE     = 32;
    localparam int QPU_XLEN          = 32;
    localparam int QPU_DMEM_OUTS_NUM = 2;
    localparam int QPU_ID_W          = 1;
    typedef logic [QPU_ID_W-1:0] id_t;
endpackage

// File: rtl/qpu_dmem_icb_arbt_if.sv
// qpu_dmem_icb_arbt_if: one ICB link (command + response channels) with master/slave views.
interface qpu_dmem_icb_arbt_if
    import qpu_dmem_icb_arbt_pkg::*;
#(
    parameter int AW = QPU_ADDR_SIZE,
    parameter int DW = QPU_XLEN
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/qpu_gnrl_id_fifo.sv
// qpu_gnrl_id_fifo: small synchronous FIFO of requester ids with full/empty flags.
module qpu_gnrl_id_fifo #(
    parameter int DW    = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          wr, rd;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign dout  = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= din;
                wptr      <= wptr == PW'(DEPTH - 1) ? '0 : wptr + PW'(1);
            end
            if (rd) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + PW'(1);
            cnt <= cnt + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/qpu_dmem_icb_arbt.sv
// qpu_dmem_icb_arbt: round-robin 2:1 ICB arbiter in front of the data memory; an id FIFO
// steers in-order memory responses back to whichever requester issued the command.
module qpu_dmem_icb_arbt
    import qpu_dmem_icb_arbt_pkg::*;
#(
    parameter int OUTS_NUM = QPU_DMEM_OUTS_NUM
) (
    input  logic clk,
    input  logic rst_n,
    qpu_dmem_icb_arbt_if.slave  r0,
    qpu_dmem_icb_arbt_if.slave  r1,
    qpu_dmem_icb_arbt_if.master m,
    output logic arbt_err
);
    id_t  rr_ptr, lock_id, gnt_id, head_id;
    logic lock, gnt_valid, cmd_hs, rsp_hs, fifo_full, fifo_empty;
    always_comb begin
        gnt_id    = lock ? lock_id : (r0.cmd_valid & r1.cmd_valid) ? rr_ptr : id_t'(r1.cmd_valid);
        gnt_valid = gnt_id[0] ? r1.cmd_valid : r0.cmd_valid;
    end
    // Full blocks issue even on a same-cycle pop so no rsp->cmd combinational path exists.
    assign m.cmd_valid = gnt_valid & ~fifo_full;
    assign m.cmd_addr  = gnt_id[0] ? r1.cmd_addr  : r0.cmd_addr;
    assign m.cmd_read  = gnt_id[0] ? r1.cmd_read  : r0.cmd_read;
    assign m.cmd_wdata = gnt_id[0] ? r1.cmd_wdata : r0.cmd_wdata;
    assign m.cmd_wmask = gnt_id[0] ? r1.cmd_wmask : r0.cmd_wmask;
    assign cmd_hs      = m.cmd_valid & m.cmd_ready;
    assign r0.cmd_ready = cmd_hs & ~gnt_id[0];
    assign r1.cmd_ready = cmd_hs & gnt_id[0];
    assign r0.rsp_valid = m.rsp_valid & ~fifo_empty & ~head_id[0];
    assign r1.rsp_valid = m.rsp_valid & ~fifo_empty & head_id[0];
    assign r0.rsp_rdata = m.rsp_rdata;
    assign r1.rsp_rdata = m.rsp_rdata;
    // Orphan responses are drained so the memory side can never wedge.
    assign m.rsp_ready = m.rsp_valid & (fifo_empty | (head_id[0] ? r1.rsp_ready : r0.rsp_ready));
    assign rsp_hs      = m.rsp_valid & m.rsp_ready & ~fifo_empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_id  <= '0;
            arbt_err <= 1'b0;
        end else begin
            if (cmd_hs) rr_ptr <= ~gnt_id;
            lock <= lock ? ~cmd_hs : (m.cmd_valid & ~m.cmd_ready);
            if (!lock) lock_id <= gnt_id;
            arbt_err <= arbt_err | (m.rsp_valid & fifo_empty);
        end
    end
    qpu_gnrl_id_fifo #(
        .DW    (QPU_ID_W),
        .DEPTH (OUTS_NUM)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs),
        .din   (gnt_id),
        .pop   (rsp_hs),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_qpu_dmem_icb_arbt.sv
// tb_qpu_dmem_icb_arbt: directed scenarios plus random traffic checked against a queue-based model.
module tb_qpu_dmem_icb_arbt;
    import qpu_dmem_icb_arbt_pkg::*;
    localparam int OUTS = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic arbt_err;
    int   n_chk = 0, n_err = 0;
    qpu_dmem_icb_arbt_if r0_if ();
    qpu_dmem_icb_arbt_if r1_if ();
    qpu_dmem_icb_arbt_if m_if ();
    qpu_dmem_icb_arbt #(.OUTS_NUM(OUTS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0       (r0_if),
        .r1       (r1_if),
        .m        (m_if),
        .arbt_err (arbt_err)
    );
    always #5 clk = ~clk;
    // Model state: who is preferred, whether a stalled grant is held, and ids awaiting responses.
    int rr, lk_id, q[$];
    bit lk, err_m, pend0, pend1, pendm;
    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask
    task automatic mdl();
        bit v0 = r0_if.cmd_valid;
        bit v1 = r1_if.cmd_valid;
        bit full = q.size() == OUTS;
        bit empty = q.size() == 0;
        int g = lk ? lk_id : (v0 && v1) ? rr : int'(v1);
        bit gv = g != 0 ? v1 : v0;
        bit mv = gv && !full;
        bit hs = mv && m_if.cmd_ready;
        int head = empty ? 0 : q[0];
        bit rv0 = m_if.rsp_valid && !empty && head == 0;
        bit rv1 = m_if.rsp_valid && !empty && head == 1;
        bit mr = m_if.rsp_valid && (empty || (head != 0 ? r1_if.rsp_ready : r0_if.rsp_ready));
        chk("m_cmd_valid", m_if.cmd_valid, mv);
        chk("r0_cmd_ready", r0_if.cmd_ready, hs && g == 0);
        chk("r1_cmd_ready", r1_if.cmd_ready, hs && g == 1);
        if (mv) begin
            chk("m_cmd_addr", m_if.cmd_addr, g != 0 ? r1_if.cmd_addr : r0_if.cmd_addr);
            chk("m_cmd_data", {m_if.cmd_read, m_if.cmd_wmask, m_if.cmd_wdata},
                g != 0 ? {r1_if.cmd_read, r1_if.cmd_wmask, r1_if.cmd_wdata}
                       : {r0_if.cmd_read, r0_if.cmd_wmask, r0_if.cmd_wdata});
        end
        chk("r0_rsp_valid", r0_if.rsp_valid, rv0);
        chk("r1_rsp_valid", r1_if.rsp_valid, rv1);
        chk("m_rsp_ready", m_if.rsp_ready, mr);
        chk("arbt_err", arbt_err, err_m);
        if (rv0) chk("r0_rdata", r0_if.rsp_rdata, m_if.rsp_rdata);
        if (rv1) chk("r1_rdata", r1_if.rsp_rdata, m_if.rsp_rdata);
        if (mr && !empty) void'(q.pop_front());
        if (hs) q.push_back(g);
        if (m_if.rsp_valid && empty) err_m = 1;
        if (lk) lk = !hs;
        else begin
            lk    = mv && !m_if.cmd_ready;
            lk_id = g;
        end
        if (hs) rr = 1 - g;
        pend0 = v0 && !(hs && g == 0);
        pend1 = v1 && !(hs && g == 1);
        pendm = m_if.rsp_valid && !mr;
    endtask
    task automatic cyc();
        @(negedge clk);
        mdl();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        r0_if.cmd_valid = 0; r0_if.cmd_addr = 0; r0_if.cmd_read = 0; r0_if.cmd_wdata = 0; r0_if.cmd_wmask = 0;
        r1_if.cmd_valid = 0; r1_if.cmd_addr = 0; r1_if.cmd_read = 0; r1_if.cmd_wdata = 0; r1_if.cmd_wmask = 0;
        r0_if.rsp_ready = 1; r1_if.rsp_ready = 1;
        m_if.cmd_ready = 0; m_if.rsp_valid = 0; m_if.rsp_rdata = 0;
    endtask
    task automatic do_reset();
        rst_n = 0;
        idle();
        q.delete();
        rr = 0; lk = 0; lk_id = 0; err_m = 0; pend0 = 0; pend1 = 0; pendm = 0;
        @(posedge clk);
        #1;
        chk("rst_outs", {m_if.cmd_valid, r0_if.cmd_ready, r1_if.cmd_ready, r0_if.rsp_valid,
                         r1_if.rsp_valid, m_if.rsp_ready, arbt_err}, 0);
        @(posedge clk);
        #1 rst_n = 1;
    endtask
    task automatic drain();
        r0_if.cmd_valid = 0; r1_if.cmd_valid = 0;
        r0_if.rsp_ready = 1; r1_if.rsp_ready = 1;
        for (int k = 0; k < OUTS + 2 && q.size() != 0; k++) begin
            m_if.rsp_valid = 1;
            m_if.rsp_rdata = $urandom;
            cyc();
        end
        m_if.rsp_valid = 0;
    endtask
    initial begin
        int got;
        do_reset();
        // single LSU read, zero-latency command, response routed to r0 only
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 32'h10; r0_if.cmd_read = 1; m_if.cmd_ready = 1;
        #2;
        chk("t1_addr", m_if.cmd_addr, 32'h10);
        chk("t1_valid", m_if.cmd_valid, 1);
        cyc();
        r0_if.cmd_valid = 0; m_if.rsp_valid = 1; m_if.rsp_rdata = 32'hDEADBEEF;
        #2;
        chk("t1_rsp_route", {r0_if.rsp_valid, r1_if.rsp_valid}, 2'b10);
        chk("t1_rdata", r0_if.rsp_rdata, 32'hDEADBEEF);
        cyc();
        m_if.rsp_valid = 0;
        // both requesting every cycle: grants alternate starting with r0
        do_reset();
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 32'h100; r0_if.cmd_read = 1;
        r1_if.cmd_valid = 1; r1_if.cmd_addr = 32'h200; r1_if.cmd_read = 1;
        m_if.cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            m_if.rsp_valid = q.size() != 0;
            #2;
            got = r1_if.cmd_ready ? 1 : r0_if.cmd_ready ? 0 : 2;
            chk("t2_grant", got, i % 2);
            cyc();
        end
        drain();
        // stalled r1 grant stays locked while r0 joins
        do_reset();
        r1_if.cmd_valid = 1; r1_if.cmd_addr = 32'h300;
        cyc();
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t3_lock_addr", m_if.cmd_addr, 32'h300);
            chk("t3_r0_wait", r0_if.cmd_ready, 0);
            cyc();
        end
        m_if.cmd_ready = 1;
        #2;
        chk("t3_r1_hs", r1_if.cmd_ready, 1);
        cyc();
        r1_if.cmd_valid = 0;
        #2;
        chk("t3_r0_next", r0_if.cmd_ready, 1);
        cyc();
        drain();
        // outstanding limit: third command waits for a response, even a same-cycle one
        do_reset();
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 32'h20; m_if.cmd_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t4_accept_n", r0_if.cmd_ready, 1);
            cyc();
        end
        #2;
        chk("t4_full_block", r0_if.cmd_ready, 0);
        cyc();
        m_if.rsp_valid = 1; m_if.rsp_rdata = 32'h1;
        #2;
        chk("t4_pop_same_cycle", r0_if.cmd_ready, 0);
        cyc();
        m_if.rsp_valid = 0;
        #2;
        chk("t4_accept_after", r0_if.cmd_ready, 1);
        cyc();
        drain();
        // write from r0 then read from r1; r1 back-pressure stalls memory
        do_reset();
        r0_if.cmd_valid = 1; r0_if.cmd_read = 0; r0_if.cmd_wdata = 32'h1234; r0_if.cmd_wmask = 4'hF;
        m_if.cmd_ready = 1;
        cyc();
        r0_if.cmd_valid = 0;
        r1_if.cmd_valid = 1; r1_if.cmd_read = 1; r1_if.cmd_addr = 32'h500;
        cyc();
        r1_if.cmd_valid = 0; r1_if.rsp_ready = 0;
        m_if.rsp_valid = 1; m_if.rsp_rdata = 32'h0;
        #2;
        chk("t5_rsp1_r0", {r0_if.rsp_valid, r1_if.rsp_valid}, 2'b10);
        cyc();
        m_if.rsp_rdata = 32'h55AA;
        #2;
        chk("t5_rsp2_r1", {r0_if.rsp_valid, r1_if.rsp_valid}, 2'b01);
        chk("t5_stall", m_if.rsp_ready, 0);
        cyc();
        cyc();
        r1_if.rsp_ready = 1;
        #2;
        chk("t5_release", m_if.rsp_ready, 1);
        chk("t5_rdata", r1_if.rsp_rdata, 32'h55AA);
        cyc();
        m_if.rsp_valid = 0;
        // orphan response: drained, sticky error until reset
        do_reset();
        m_if.rsp_valid = 1;
        #2;
        chk("t6_drain", {m_if.rsp_ready, r0_if.rsp_valid, r1_if.rsp_valid}, 3'b100);
        chk("t6_err_pre", arbt_err, 0);
        cyc();
        m_if.rsp_valid = 0;
        cyc();
        cyc();
        chk("t6_sticky", arbt_err, 1);
        // reset discards an outstanding id, so its late response is an orphan
        do_reset();
        r0_if.cmd_valid = 1; m_if.cmd_ready = 1;
        cyc();
        do_reset();
        m_if.rsp_valid = 1;
        cyc();
        m_if.rsp_valid = 0;
        #2;
        chk("t7_late_rsp_err", arbt_err, 1);
        // random traffic respecting ICB hold rules
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (!pend0) begin
                r0_if.cmd_valid = $urandom_range(0, 9) < 6;
                r0_if.cmd_addr = $urandom; r0_if.cmd_read = 1'($urandom);
                r0_if.cmd_wdata = $urandom; r0_if.cmd_wmask = 4'($urandom);
            end
            if (!pend1) begin
                r1_if.cmd_valid = $urandom_range(0, 9) < 5;
                r1_if.cmd_addr = $urandom; r1_if.cmd_read = 1'($urandom);
                r1_if.cmd_wdata = $urandom; r1_if.cmd_wmask = 4'($urandom);
            end
            m_if.cmd_ready = $urandom_range(0, 9) < 7;
            r0_if.rsp_ready = 1;
            r1_if.rsp_ready = $urandom_range(0, 9) < 6;
            if (!pendm) begin
                m_if.rsp_valid = q.size() != 0 && $urandom_range(0, 9) < 6;
                m_if.rsp_rdata = $urandom;
            end
            cyc();
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
